// File: rtl/sdram_port_arbiter.sv
// Two-port Avalon-MM arbiter in front of one SDRAM controller: VGA reader (port 0, priority)
// and GPU master (port 1), with an owner FIFO routing pipelined read data back to its issuer.
module sdram_port_arbiter #(
    parameter int unsigned MAX_PENDING  = 8,
    parameter int unsigned STARVE_LIMIT = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] p0_address,
    input  logic        p0_read,
    output logic [31:0] p0_read_data,
    output logic        p0_wait_request,
    output logic        p0_read_data_valid,
    input  logic [31:0] p1_address,
    input  logic        p1_read,
    input  logic        p1_write,
    input  logic [31:0] p1_write_data,
    input  logic [3:0]  p1_byte_enable,
    output logic [31:0] p1_read_data,
    output logic        p1_wait_request,
    output logic        p1_read_data_valid,
    output logic [31:0] master_address,
    output logic        master_read,
    output logic        master_write,
    output logic [31:0] master_write_data,
    output logic [3:0]  master_byte_enable,
    input  logic [31:0] master_read_data,
    input  logic        master_wait_request,
    input  logic        master_read_data_valid,
    output logic        err_orphan
);
    localparam int unsigned PW = (MAX_PENDING > 1) ? $clog2(MAX_PENDING) : 1;
    localparam int unsigned CW = PW + 1;
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] HOLD0 = 2'd1;
    localparam logic [1:0] HOLD1 = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          err_orphan_q, err_orphan_d;
    logic          owner_q [MAX_PENDING];
    logic          owner_d [MAX_PENDING];

    logic p1_req, gnt_valid, gnt_id, cmd_read, cmd_write;
    logic fifo_full, fifo_empty, read_blocked, accept, push, pop;

    assign p1_req     = p1_read | p1_write;
    assign fifo_full  = (count_q == CW'(MAX_PENDING));
    assign fifo_empty = (count_q == '0);

    // Grant is combinational in IDLE so a request reaches the SDRAM in the same cycle.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_id    = 1'b0;
        case (state_q)
            HOLD0: gnt_valid = 1'b1;
            HOLD1: begin
                gnt_valid = 1'b1;
                gnt_id    = 1'b1;
            end
            default: begin
                if (p1_req && ((starve_q == SW'(STARVE_LIMIT)) || !p0_read)) begin
                    gnt_valid = 1'b1;
                    gnt_id    = 1'b1;
                end else if (p0_read) begin
                    gnt_valid = 1'b1;
                end
            end
        endcase
    end

    assign cmd_read     = gnt_valid & (gnt_id ? p1_read : p0_read);
    assign cmd_write    = gnt_valid & gnt_id & p1_write;
    assign read_blocked = cmd_read & fifo_full;

    assign master_read        = resetn & cmd_read & ~fifo_full;
    assign master_write       = resetn & cmd_write;
    assign master_address     = gnt_id ? p1_address : p0_address;
    assign master_write_data  = p1_write_data;
    assign master_byte_enable = gnt_id ? p1_byte_enable : 4'hF;

    assign accept = (master_read | master_write) & ~master_wait_request;
    assign push   = accept & master_read;
    assign pop    = master_read_data_valid & ~fifo_empty;

    assign p0_wait_request = ~(resetn & gnt_valid & ~gnt_id) | master_wait_request | read_blocked;
    assign p1_wait_request = ~(resetn & gnt_valid & gnt_id) | master_wait_request | read_blocked;

    assign p0_read_data       = master_read_data;
    assign p1_read_data       = master_read_data;
    assign p0_read_data_valid = resetn & pop & ~owner_q[rd_ptr_q];
    assign p1_read_data_valid = resetn & pop & owner_q[rd_ptr_q];
    assign err_orphan         = err_orphan_q;

    always_comb begin
        state_d = IDLE;
        if (gnt_valid && !accept) begin
            state_d = gnt_id ? HOLD1 : HOLD0;
        end
    end

    always_comb begin
        owner_d  = owner_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            owner_d[wr_ptr_q] = gnt_id;
            wr_ptr_d          = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        err_orphan_d = err_orphan_q | (master_read_data_valid & fifo_empty);
    end

    // Starvation counter only runs while port 1 is actually waiting.
    always_comb begin
        starve_d = starve_q;
        if (!p1_req || (accept && gnt_id)) begin
            starve_d = '0;
        end else if (accept && (starve_q != SW'(STARVE_LIMIT))) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            starve_q     <= '0;
            err_orphan_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            starve_q     <= starve_d;
            err_orphan_q <= err_orphan_d;
        end
        owner_q <= owner_d;
    end
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scoreboard bench for sdram_port_arbiter: expected SDRAM commands and read returns are queued
// by the stimulus and popped by a monitor when the DUT presents them.
module tb_sdram_port_arbiter;
    localparam int unsigned LAT = 3;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] p0_address = '0;
    logic        p0_read = 1'b0;
    logic [31:0] p0_read_data;
    logic        p0_wait_request, p0_read_data_valid;
    logic [31:0] p1_address = '0;
    logic        p1_read = 1'b0;
    logic        p1_write = 1'b0;
    logic [31:0] p1_write_data = '0;
    logic [3:0]  p1_byte_enable = '0;
    logic [31:0] p1_read_data;
    logic        p1_wait_request, p1_read_data_valid;
    logic [31:0] master_address, master_write_data;
    logic        master_read, master_write;
    logic [3:0]  master_byte_enable;
    logic [31:0] master_read_data = '0;
    logic        master_wait_request = 1'b0;
    logic        master_read_data_valid;
    logic        err_orphan;

    logic        resp_valid = 1'b0;
    logic        man_valid = 1'b0;
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          budget = 0;
    logic [69:0] cmd_q[$];
    logic [33:0] ret_q[$];
    logic [63:0] resp_q[$];

    assign master_read_data_valid = resp_valid | man_valid;

    sdram_port_arbiter #(.MAX_PENDING(8), .STARVE_LIMIT(16)) dut (
        .clk(clk), .resetn(resetn),
        .p0_address(p0_address), .p0_read(p0_read), .p0_read_data(p0_read_data),
        .p0_wait_request(p0_wait_request), .p0_read_data_valid(p0_read_data_valid),
        .p1_address(p1_address), .p1_read(p1_read), .p1_write(p1_write),
        .p1_write_data(p1_write_data), .p1_byte_enable(p1_byte_enable),
        .p1_read_data(p1_read_data), .p1_wait_request(p1_wait_request),
        .p1_read_data_valid(p1_read_data_valid),
        .master_address(master_address), .master_read(master_read),
        .master_write(master_write), .master_write_data(master_write_data),
        .master_byte_enable(master_byte_enable), .master_read_data(master_read_data),
        .master_wait_request(master_wait_request),
        .master_read_data_valid(master_read_data_valid), .err_orphan(err_orphan)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] beat_data(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_read(input int port, input logic [31:0] addr, input logic [3:0] be);
        cmd_q.push_back({1'b1, 1'b0, addr, be, 32'h0});
        ret_q.push_back({port == 1, port == 0, beat_data(addr)});
    endtask

    task automatic issue_read(input int port, input logic [31:0] addr, input logic [3:0] be);
        logic done;
        expect_read(port, addr, (port == 0) ? 4'hF : be);
        if (port == 0) begin
            p0_read    = 1'b1;
            p0_address = addr;
        end else begin
            p1_read        = 1'b1;
            p1_address     = addr;
            p1_byte_enable = be;
        end
        done = 1'b0;
        for (int n = 0; n < 100 && !done; n++) begin
            @(negedge clk);
            done = (port == 0) ? !p0_wait_request : !p1_wait_request;
            tick();
        end
        check("issue_done", 70'(done), 70'(1'b1));
        p0_read = 1'b0;
        p1_read = 1'b0;
    endtask

    // Monitor: every accepted command and every returned beat is matched against the queues.
    initial begin
        logic [69:0] act;
        logic [33:0] ret;
        forever begin
            @(negedge clk);
            if (resetn) begin
                if ((master_read || master_write) && !master_wait_request) begin
                    act = {master_read, master_write, master_address, master_byte_enable,
                           master_write ? master_write_data : 32'h0};
                    if (cmd_q.size() == 0) check("cmd_unexpected", act, 70'h0);
                    else check("cmd", act, cmd_q.pop_front());
                    if (master_read) resp_q.push_back({32'(cyc + int'(LAT)),
                                                       beat_data(master_address)});
                end
                if (p0_read_data_valid || p1_read_data_valid) begin
                    ret = {p1_read_data_valid, p0_read_data_valid,
                           p0_read_data_valid ? p0_read_data : p1_read_data};
                    if (ret_q.size() == 0) check("ret_unexpected", 70'(ret), 70'h0);
                    else check("ret", 70'(ret), 70'(ret_q.pop_front()));
                end
            end
        end
    end

    // SDRAM model: fixed-latency in-order returns, rate-limited by budget.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #2;
            if (resetn && budget > 0 && resp_q.size() > 0 && resp_q[0][63:32] <= 32'(cyc)) begin
                resp_valid       = 1'b1;
                master_read_data = resp_q[0][31:0];
                void'(resp_q.pop_front());
                budget--;
            end else begin
                resp_valid = 1'b0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        // Reset with both ports requesting
        p0_read = 1'b1;
        p1_read = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_cmd", 70'({master_read, master_write}), 70'(2'b00));
            check("rst_wait", 70'({p0_wait_request, p1_wait_request}), 70'(2'b11));
            check("rst_orphan", 70'(err_orphan), 70'(1'b0));
            check("rst_valid", 70'({p0_read_data_valid, p1_read_data_valid}), 70'(2'b00));
        end
        tick();
        resetn  = 1'b1;
        p0_read = 1'b0;
        p1_read = 1'b0;
        budget  = 1000000;
        tick();

        // Starvation: 16 port-0 grants, then port 1 forced once
        p0_read = 1'b1; p0_address = 32'h100;
        p1_read = 1'b1; p1_address = 32'h200; p1_byte_enable = 4'h3;
        for (int k = 0; k < 16; k++) expect_read(0, 32'h100, 4'hF);
        expect_read(1, 32'h200, 4'h3);
        expect_read(0, 32'h104, 4'hF);
        expect_read(1, 32'h204, 4'h3);
        for (int k = 0; k < 17; k++) begin
            @(negedge clk);
            check("starve_grant", 70'({p1_wait_request, p0_wait_request}),
                  70'((k < 16) ? 2'b10 : 2'b01));
            tick();
        end
        p0_address = 32'h104;
        p1_address = 32'h204;
        @(negedge clk);
        check("starve_reset", 70'({p1_wait_request, p0_wait_request}), 70'(2'b10));
        tick();
        p0_read = 1'b0;
        @(negedge clk);
        check("p1_after_p0", 70'({p1_wait_request, p0_wait_request}), 70'(2'b01));
        tick();
        p1_read = 1'b0;
        repeat (8) tick();

        // Port-1 write held by SDRAM back-pressure while port 0 waits
        p1_write = 1'b1; p1_address = 32'h40;
        p1_write_data = 32'hDEADBEEF; p1_byte_enable = 4'h5;
        master_wait_request = 1'b1;
        cmd_q.push_back({1'b0, 1'b1, 32'h40, 4'h5, 32'hDEADBEEF});
        expect_read(0, 32'h300, 4'hF);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("hold_cmd", {master_read, master_write, master_address, master_byte_enable,
                               master_write_data}, {1'b0, 1'b1, 32'h40, 4'h5, 32'hDEADBEEF});
            check("hold_wait", 70'({p0_wait_request, p1_wait_request}), 70'(2'b11));
            tick();
            if (k == 0) begin
                p0_read    = 1'b1;
                p0_address = 32'h300;
            end
            if (k == 4) master_wait_request = 1'b0;
        end
        @(negedge clk);
        check("hold_accept", 70'({p1_wait_request, p0_wait_request, master_write}), 70'(3'b011));
        tick();
        p1_write = 1'b0;
        @(negedge clk);
        check("post_hold_p0", 70'({master_read, p0_wait_request, master_address}),
              70'({1'b1, 1'b0, 32'h300}));
        tick();
        p0_read = 1'b0;
        repeat (6) tick();

        // Owner FIFO full: ninth read stalls until a pop, then issues the cycle after
        budget = 0;
        for (int i = 0; i < 8; i++) issue_read(i % 2, 32'h1000 + 32'(4 * i), 4'h9);
        expect_read(0, 32'h2000, 4'hF);
        p0_read = 1'b1; p0_address = 32'h2000;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("full_block", 70'({master_read, p0_wait_request}), 70'(2'b01));
            tick();
        end
        budget = 1;
        @(negedge clk);
        check("full_pop", 70'({p0_read_data_valid, p1_read_data_valid, master_read,
                              p0_wait_request}), 70'(4'b1001));
        tick();
        @(negedge clk);
        check("full_issue", 70'({master_read, p0_wait_request, master_address}),
              70'({1'b1, 1'b0, 32'h2000}));
        tick();
        p0_read = 1'b0;

        // Interleaved reads draining a full FIFO with 3-cycle returns
        budget = 1000000;
        for (int i = 0; i < 20; i++) issue_read((i % 2 == 0) ? 1 : 0, 32'h3000 + 32'(4 * i), 4'hC);
        repeat (20) tick();

        // Orphan beat
        @(negedge clk);
        check("orphan_pre", 70'(err_orphan), 70'(1'b0));
        tick();
        man_valid = 1'b1;
        @(negedge clk);
        check("orphan_novalid", 70'({p0_read_data_valid, p1_read_data_valid}), 70'(2'b00));
        tick();
        man_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("orphan_sticky", 70'(err_orphan), 70'(1'b1));
            tick();
        end
        issue_read(1, 32'h500, 4'hF);
        repeat (6) tick();
        @(negedge clk);
        check("orphan_sticky_traffic", 70'(err_orphan), 70'(1'b1));
        tick();
        resetn = 1'b0;
        tick();
        @(negedge clk);
        check("orphan_cleared", 70'(err_orphan), 70'(1'b0));
        tick();
        resetn = 1'b1;

        check("cmd_q_drained", 70'(cmd_q.size()), 70'(0));
        check("ret_q_drained", 70'(ret_q.size()), 70'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
